// File: rtl/bt656_capture_ctrl.sv
// bt656_capture_ctrl: sequences one interlaced frame (or back-to-back frames)
// from the BT.656 decoder stream into a 16-bit frame memory via a small write FIFO.
//   TD_CLK_27    27 MHz clock, rising edge
//   reset        asynchronous active-low reset
//   YCbCr        decoder pixel word
//   field        decoder field flag (0 = first field)
//   active_video decoder active-line qualifier
//   Data_Valid   decoder word strobe
//   start        one-cycle capture command (accepted only when idle)
//   continuous   1 = capture frames back-to-back
//   mem_req      write request (FIFO non-empty)
//   mem_gnt      arbiter grant; write completes on mem_req && mem_gnt
//   mem_addr     write address (FIFO head)
//   mem_wdata    write data (FIFO head)
//   busy         capture in progress
//   done         one-cycle frame-complete pulse
//   overflow     sticky write-drop flag, cleared by the next accepted start
module bt656_capture_ctrl #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 244,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              TD_CLK_27,
  input  logic              reset,
  input  logic [15:0]       YCbCr,
  input  logic              field,
  input  logic              active_video,
  input  logic              Data_Valid,
  input  logic              start,
  input  logic              continuous,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]     H_END     = PW'(H_ACTIVE);
  localparam logic [LW-1:0]     V_END     = LW'(V_ACTIVE);
  localparam logic [AW:0]       FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(2 * H_ACTIVE);
  localparam logic [ADDR_W-1:0] F1_BASE   = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DRAIN} state_t;

  state_t              state_q;
  logic                field_q, av_q, ovf_q;
  logic [PW-1:0]       pix_q;
  logic [LW-1:0]       line_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W+15:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q;
  logic                fs_edge, ft_edge, eol, push, pop, full, empty, wr_en, drain_done;

  // base_q holds (2*line + field)*H_ACTIVE, so the address needs only an adder
  assign fs_edge    = field_q & ~field;
  assign ft_edge    = ~field_q & field;
  assign eol        = av_q & ~active_video & (pix_q != '0);
  assign empty      = cnt_q == '0;
  assign full       = cnt_q == FULL_CNT;
  assign pop        = mem_req & mem_gnt;
  assign push       = state_q == CAPT && Data_Valid && active_video && pix_q < H_END && line_q < V_END;
  assign wr_en      = push & (~full | pop);
  assign drain_done = state_q == DRAIN && empty;
  assign done       = (state_q == CAPT && fs_edge && continuous) || drain_done;
  assign busy       = state_q != IDLE && !drain_done;
  assign mem_req    = ~empty;
  assign overflow   = ovf_q;
  assign {mem_addr, mem_wdata} = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge TD_CLK_27)
    if (wr_en) mem_q[wr_q] <= {base_q + ADDR_W'(pix_q), YCbCr};

  always_ff @(posedge TD_CLK_27 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      field_q <= 1'b1;
      av_q    <= 1'b0;
      ovf_q   <= 1'b0;
      pix_q   <= '0;
      line_q  <= '0;
      base_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      field_q <= field;
      av_q    <= active_video;
      case (state_q)
        IDLE: if (start) begin
          state_q <= ARMED;
          ovf_q   <= 1'b0;
        end
        ARMED: if (fs_edge) begin
          state_q <= CAPT;
          pix_q   <= '0;
          line_q  <= '0;
          base_q  <= '0;
        end
        CAPT: if (fs_edge) begin
          state_q <= continuous ? CAPT : DRAIN;
          pix_q   <= '0;
          line_q  <= '0;
          base_q  <= '0;
        end else if (ft_edge) begin
          pix_q   <= '0;
          line_q  <= '0;
          base_q  <= F1_BASE;
        end else if (eol) begin
          pix_q   <= '0;
          // line saturates at V_ACTIVE so later lines stay clipped
          if (line_q < V_END) begin
            line_q <= line_q + 1'b1;
            base_q <= base_q + LINE_STEP;
          end
        end else if (push) pix_q <= pix_q + 1'b1;
        default: if (empty) state_q <= IDLE;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end
  end
endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// tb_bt656_capture_ctrl: directed bench for bt656_capture_ctrl with H_ACTIVE=4, V_ACTIVE=2.
module tb_bt656_capture_ctrl;
  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] YCbCr = '0;
  logic        field = 1'b1, active_video = 1'b0, Data_Valid = 1'b0, start = 1'b0, continuous = 1'b0;
  logic        mem_gnt = 1'b1;
  logic        mem_req, busy, done, overflow;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  int          passed = 0, fails = 0, total = 0;
  logic [34:0] exp_q [$];

  bt656_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19), .FIFO_DEPTH(8)) dut (
    .TD_CLK_27(clk), .reset(reset), .YCbCr(YCbCr), .field(field), .active_video(active_video),
    .Data_Valid(Data_Valid), .start(start), .continuous(continuous), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      Data_Valid = 1'b1;
      active_video = 1'b1;
      YCbCr = d + 16'(i);
      tick();
    end
    Data_Valid = 1'b0;
    active_video = 1'b0;
    tick();
    tick();
  endtask

  task automatic expw(input int n, input logic [18:0] a, input logic [15:0] d);
    for (int i = 0; i < n; i++) exp_q.push_back({a + 19'(i), d + 16'(i)});
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk({tag, "_done"}, 35'(seen), 35'd1);
    if (seen) chk({tag, "_busy_with_done"}, 35'(busy), 35'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 35'(done), 35'd0);
    chk({tag, "_idle"}, 35'(busy), 35'd0);
  endtask

  always @(negedge clk)
    if (reset && mem_req && mem_gnt) begin
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $error("FAIL unexpected_write observed=%0h expected=none", {mem_addr, mem_wdata});
      end else chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_req", 35'(mem_req), 35'd0);
    chk("rst_busy", 35'(busy), 35'd0);
    chk("rst_done", 35'(done), 35'd0);
    chk("rst_ovf", 35'(overflow), 35'd0);
    chk("rst_addr", 35'(mem_addr), 35'd0);
    reset = 1'b1;
    tick();
    // single frame, grant always on
    start = 1'b1; tick(); start = 1'b0;
    chk("armed_busy", 35'(busy), 35'd1);
    line(2, 16'hDEAD);
    chk("armed_no_req", 35'(mem_req), 35'd0);
    field = 1'b0; tick();
    expw(4, 19'd0, 16'h1000); expw(4, 19'd8, 16'h1004);
    line(4, 16'h1000); line(4, 16'h1004);
    field = 1'b1; tick();
    expw(4, 19'd4, 16'h1008); expw(4, 19'd12, 16'h100C);
    line(4, 16'h1008); line(4, 16'h100C);
    field = 1'b0;
    wait_done("single");
    chk("single_all_written", 35'(exp_q.size()), 35'd0);
    // stall with grant low: FIFO fills, ninth push dropped
    mem_gnt = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    field = 1'b1; tick(); field = 1'b0; tick();
    line(4, 16'h2000);
    chk("stall_head_addr", 35'(mem_addr), 35'd0);
    chk("stall_head_data", 35'(mem_wdata), 35'h2000);
    line(4, 16'h2004);
    chk("stall_full_no_ovf", 35'(overflow), 35'd0);
    field = 1'b1; tick();
    line(1, 16'h2008);
    chk("stall_ovf", 35'(overflow), 35'd1);
    chk("stall_head_addr2", 35'(mem_addr), 35'd0);
    chk("stall_head_data2", 35'(mem_wdata), 35'h2000);
    start = 1'b1; tick(); start = 1'b0;
    chk("capt_start_ovf", 35'(overflow), 35'd1);
    chk("capt_start_busy", 35'(busy), 35'd1);
    expw(4, 19'd0, 16'h2000); expw(4, 19'd8, 16'h2004);
    mem_gnt = 1'b1;
    repeat (10) tick();
    chk("stall_drained", 35'(exp_q.size()), 35'd0);
    chk("stall_req_low", 35'(mem_req), 35'd0);
    field = 1'b0;
    wait_done("stall");
    chk("ovf_sticky", 35'(overflow), 35'd1);
    // line and field clipping
    start = 1'b1; tick(); start = 1'b0;
    chk("start_clears_ovf", 35'(overflow), 35'd0);
    field = 1'b1; tick(); field = 1'b0; tick();
    expw(4, 19'd0, 16'h3000); line(6, 16'h3000);
    expw(4, 19'd8, 16'h3010); line(4, 16'h3010);
    line(4, 16'h3020);
    field = 1'b1; tick(); field = 1'b0;
    wait_done("clip");
    chk("clip_all_written", 35'(exp_q.size()), 35'd0);
    // continuous capture across three frame-start edges
    continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    field = 1'b1; tick(); field = 1'b0;
    @(negedge clk);
    chk("cont_edge1_done", 35'(done), 35'd0);
    tick();
    expw(4, 19'd0, 16'h4000); line(4, 16'h4000);
    field = 1'b1; tick(); field = 1'b0;
    @(negedge clk);
    chk("cont_edge2_done", 35'(done), 35'd1);
    chk("cont_edge2_busy", 35'(busy), 35'd1);
    tick();
    expw(4, 19'd0, 16'h4010); line(4, 16'h4010);
    field = 1'b1; tick(); field = 1'b0;
    @(negedge clk);
    chk("cont_edge3_done", 35'(done), 35'd1);
    chk("cont_edge3_busy", 35'(busy), 35'd1);
    tick();
    chk("cont_done_one_cycle", 35'(done), 35'd0);
    continuous = 1'b0;
    expw(4, 19'd0, 16'h4020); line(4, 16'h4020);
    field = 1'b1; tick(); field = 1'b0;
    wait_done("cont_end");
    chk("cont_all_written", 35'(exp_q.size()), 35'd0);
    // asynchronous reset mid-capture with FIFO entries pending
    mem_gnt = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    field = 1'b1; tick(); field = 1'b0; tick();
    line(3, 16'h5000);
    chk("pre_rst_req", 35'(mem_req), 35'd1);
    chk("pre_rst_busy", 35'(busy), 35'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", 35'(mem_req), 35'd0);
    chk("async_rst_busy", 35'(busy), 35'd0);
    tick();
    reset = 1'b1;
    mem_gnt = 1'b1;
    repeat (3) tick();
    chk("post_rst_req", 35'(mem_req), 35'd0);
    chk("post_rst_busy", 35'(busy), 35'd0);
    chk("final_queue_empty", 35'(exp_q.size()), 35'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
